// File: rtl/picosoc_bus_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// Holds the grant until the slave completes and forces an error completion on hung slaves.
module picosoc_bus_arbiter #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  localparam int unsigned   CW      = (TIMEOUT < 32'd2) ? 1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [CW-1:0] LIMIT   = CW'((TIMEOUT == 32'd0) ? 32'd0 : (TIMEOUT - 32'd1));
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   err_addr_q, err_addr_d;

  logic          busy, sel_m1, own_valid, timeout_hit, done;
  logic [31:0]   rdata_mux;

  assign busy      = (state_q == BUSY);
  // Data path follows master 0 whenever the bus is idle.
  assign sel_m1    = busy & owner_q;
  assign own_valid = owner_q ? m1_valid : m0_valid;
  assign timeout_hit = (TIMEOUT != 32'd0) & busy & own_valid & (cnt_q == LIMIT) & ~s_ready;
  assign done      = s_ready | timeout_hit;
  assign rdata_mux = timeout_hit ? ERR_RDATA : s_rdata;

  assign s_addr  = sel_m1 ? m1_addr  : m0_addr;
  assign s_wdata = sel_m1 ? m1_wdata : m0_wdata;
  assign s_wstrb = sel_m1 ? m1_wstrb : m0_wstrb;
  assign s_instr = sel_m1 ? m1_instr : m0_instr;

  assign err      = err_q;
  assign err_addr = err_addr_q;

  always_comb begin
    s_valid  = 1'b0;
    grant    = 2'b00;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = 32'd0;
    m1_rdata = 32'd0;
    if (busy) begin
      s_valid = own_valid;
      if (owner_q) begin
        grant    = 2'b10;
        m1_ready = own_valid & done & ~reset;
        m1_rdata = rdata_mux;
      end else begin
        grant    = 2'b01;
        m0_ready = own_valid & done & ~reset;
        m0_rdata = rdata_mux;
      end
    end else begin
      s_valid = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_valid | m1_valid) begin
          state_d = BUSY;
          owner_d = (m0_valid & m1_valid) ? ~last_q : m1_valid;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A dropped request aborts the access exactly like a completion, minus the ready.
        if (~own_valid | done) begin
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    // A new timeout beats a simultaneous clear and re-captures the address.
    if (timeout_hit & (~err_q | err_clr)) begin
      err_d      = 1'b1;
      err_addr_d = s_addr;
    end else begin
      err_addr_d = err_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Self-checking bench for picosoc_bus_arbiter: directed scenarios followed by random
// transactions, each predicted at transaction level from the arbitration/timeout rules.
module tb_picosoc_bus_arbiter;

  localparam int          TMO  = 8;
  localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        err, err_clr;
  logic [31:0] err_addr;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          ref_last;
  bit          ref_err;
  logic [31:0] ref_err_addr;

  always #5 clk = ~clk;

  picosoc_bus_arbiter #(.TIMEOUT(TMO), .ERR_RDATA(ERRD)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .err(err), .err_addr(err_addr), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle(input bit clr);
    @(negedge clk);
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; err_clr = clr;
    #1;
    chk("idle_grant", {30'd0, grant}, 32'd0);
    chk("idle_svalid", {31'd0, s_valid}, 32'd0);
    chk("idle_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("idle_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("idle_m0_rdata", m0_rdata, 32'd0);
    chk("idle_m1_rdata", m1_rdata, 32'd0);
    chk("idle_err", {31'd0, err}, {31'd0, ref_err});
    chk("idle_err_addr", err_addr, ref_err_addr);
    if (clr) ref_err = 1'b0;
  endtask

  // One arbitration cycle plus the BUSY cycles of a single access; lat = BUSY cycles
  // the slave waits before raising s_ready (lat+1 > TMO means the slave never answers).
  task automatic do_txn(input bit r0, input bit r1, input int lat,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [3:0] st0, input logic [3:0] st1,
                        input logic [31:0] rd, input bit clr_at_done);
    bit          win, tmo;
    int          done_b;
    logic [31:0] wa, ww;
    logic [3:0]  wst;
    logic        wi;
    logic [1:0]  g;
    win    = (r0 && r1) ? !ref_last : r1;
    tmo    = (lat + 1 > TMO);
    done_b = tmo ? TMO : lat + 1;
    g      = win ? 2'b10 : 2'b01;
    @(negedge clk);
    m0_valid = r0; m1_valid = r1;
    m0_addr = a0; m1_addr = a1; m0_wdata = w0; m1_wdata = w1;
    m0_wstrb = st0; m1_wstrb = st1;
    m0_instr = 1'($urandom); m1_instr = 1'($urandom);
    s_ready = 1'b0; s_rdata = rd; err_clr = 1'b0;
    wa = win ? a1 : a0; ww = win ? w1 : w0; wst = win ? st1 : st0;
    wi = win ? m1_instr : m0_instr;
    #1;
    chk("arb_grant", {30'd0, grant}, 32'd0);
    chk("arb_svalid", {31'd0, s_valid}, 32'd0);
    chk("arb_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("arb_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("arb_err", {31'd0, err}, {31'd0, ref_err});
    chk("arb_err_addr", err_addr, ref_err_addr);
    for (int b = 1; b <= done_b; b++) begin
      @(negedge clk);
      if (win) begin
        m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom); m0_instr = 1'($urandom);
      end else begin
        m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom); m1_instr = 1'($urandom);
      end
      s_ready = (b == lat + 1);
      err_clr = clr_at_done && (b == done_b);
      #1;
      chk("busy_grant", {30'd0, grant}, {30'd0, g});
      chk("busy_svalid", {31'd0, s_valid}, 32'd1);
      chk("busy_saddr", s_addr, wa);
      chk("busy_swdata", s_wdata, ww);
      chk("busy_swstrb", {28'd0, s_wstrb}, {28'd0, wst});
      chk("busy_sinstr", {31'd0, s_instr}, {31'd0, wi});
      chk("owner_ready", {31'd0, (win ? m1_ready : m0_ready)}, {31'd0, (b == done_b)});
      chk("other_ready", {31'd0, (win ? m0_ready : m1_ready)}, 32'd0);
      chk("other_rdata", (win ? m0_rdata : m1_rdata), 32'd0);
      if (b == done_b) chk("owner_rdata", (win ? m1_rdata : m0_rdata), (tmo ? ERRD : rd));
      chk("busy_err", {31'd0, err}, {31'd0, ref_err});
      chk("busy_err_addr", err_addr, ref_err_addr);
    end
    ref_last = win;
    if (tmo && (!ref_err || clr_at_done)) begin
      ref_err = 1'b1; ref_err_addr = wa;
    end else if (clr_at_done) begin
      ref_err = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; err_clr = 1'b0; s_ready = 1'b0; s_rdata = 32'd0;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ref_last = 1'b1; ref_err = 1'b0; ref_err_addr = 32'd0;
    idle_cycle(1'b0);

    // contention: both request continuously, grants alternate starting with m0
    for (int i = 0; i < 4; i++)
      do_txn(1'b1, 1'b1, 1, $urandom, $urandom, $urandom, $urandom, 4'd0, 4'd0, $urandom, 1'b0);

    // single read by m0
    do_txn(1'b1, 1'b0, 3, 32'h0000_0010, $urandom, 32'd0, $urandom, 4'd0, 4'd0, 32'hDEAD_BEEF, 1'b0);
    idle_cycle(1'b0);

    // write forwarded from m1 while m0 data wiggles
    do_txn(1'b0, 1'b1, 2, $urandom, 32'h0200_0004, $urandom, 32'h1234_5678, 4'hF, 4'b0011,
           $urandom, 1'b0);

    // timeouts: first latches err_addr, second leaves it alone, then clear
    do_txn(1'b0, 1'b1, 100, $urandom, 32'h0300_0000, $urandom, $urandom, 4'd0, 4'd0, 32'h0BAD_0001, 1'b0);
    do_txn(1'b1, 1'b0, 100, 32'h0400_0000, $urandom, $urandom, $urandom, 4'd0, 4'd0, 32'h0BAD_0002, 1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // boundary: s_ready in the TMO-th BUSY cycle is a normal completion
    do_txn(1'b1, 1'b0, TMO - 1, 32'h0000_0444, $urandom, $urandom, $urandom, 4'd0, 4'd0, 32'hCAFE_F00D, 1'b0);
    idle_cycle(1'b0);

    // timeout coinciding with err_clr: set wins and the address is refreshed
    do_txn(1'b1, 1'b0, 100, 32'h0500_0000, $urandom, $urandom, $urandom, 4'd0, 4'd0, $urandom, 1'b0);
    do_txn(1'b0, 1'b1, 100, $urandom, 32'h0600_0000, $urandom, $urandom, 4'd0, 4'd0, $urandom, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // abort: m0 drops valid mid-BUSY while m1 is pending
    @(negedge clk);
    m0_valid = 1'b1; m1_valid = 1'b0; m0_addr = 32'h0000_0100; s_ready = 1'b0; err_clr = 1'b0;
    #1 chk("abort_idle_grant", {30'd0, grant}, 32'd0);
    @(negedge clk);
    m1_valid = 1'b1; m1_addr = 32'h0000_0200;
    #1;
    chk("abort_busy_grant", {30'd0, grant}, 32'd1);
    chk("abort_busy_saddr", s_addr, 32'h0000_0100);
    @(negedge clk);
    m0_valid = 1'b0;
    #1;
    chk("abort_svalid", {31'd0, s_valid}, 32'd0);
    chk("abort_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("abort_m1_ready", {31'd0, m1_ready}, 32'd0);
    ref_last = 1'b0;
    do_txn(1'b0, 1'b1, 2, $urandom, 32'h0000_0200, $urandom, $urandom, 4'd0, 4'd0, 32'h5555_AAAA, 1'b0);
    idle_cycle(1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(1, 3);
      do_txn(r[0], r[1], $urandom_range(0, 10), $urandom, $urandom, $urandom, $urandom,
             4'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 7) == 0));
    end
    idle_cycle(1'b0);

    // reset in the middle of a BUSY access with err set
    do_txn(1'b1, 1'b0, 100, 32'h0700_0000, $urandom, $urandom, $urandom, 4'd0, 4'd0, $urandom, 1'b0);
    @(negedge clk);
    m0_valid = 1'b1; m1_valid = 1'b0; m0_addr = 32'h0000_0800; s_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    #1 chk("pre_reset_grant", {30'd0, grant}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ref_last = 1'b1; ref_err = 1'b0; ref_err_addr = 32'd0;
    do_txn(1'b1, 1'b1, 1, $urandom, $urandom, $urandom, $urandom, 4'd0, 4'd0, $urandom, 1'b0);
    idle_cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
